// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the dual-port SRAM arbiter.
// Provides default geometry and EMA settings, the request bundle seen by DMA
// channel engines, and the response tag that travels alongside each read.
package sram_arb_pkg;

  localparam int         ADDR_W_DEF = 8;
  localparam int         DATA_W_DEF = 64;
  localparam logic [2:0] EMA_DEF    = 3'b011;
  localparam logic [1:0] EMAW_DEF   = 2'b01;

  // Widest requester id the arbiter supports (up to 8 requesters).
  localparam int         NREQ_MAX   = 8;
  localparam int         ID_W       = 3;

  // One requester's command at the default geometry.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  // Read-return tag: marks an in-flight read and who issued it.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  // True when the tag carries a live read belonging to requester idx.
  function automatic logic tag_hit(input tag_t t, input int idx);
    return t.valid && (t.id == ID_W'(idx));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered start pointer.
// The search starts at ptr and wraps; eligible = req & mask. When advance is
// high the pointer moves to one past the granted requester, otherwise it holds.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] eligible;

  assign eligible = req & mask;

  // Pick the first eligible requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    sum       = '0;
    idx       = '0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, ptr} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Move the pointer one past an accepted grant so the winner goes to the back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/sram_dp_arbiter.sv
// Dual-port SRAM arbiter: shares one 256x64 dual-port macro among NREQ DMA
// requesters with one round-robin arbiter per port. Grants are combinational,
// macro pins are registered, and read data returns two cycles after the grant
// through a per-port tag pipe. When both ports return reads in the same cycle
// the B word is held for one extra cycle on the shared response bus.
// Optional build macro SRAM_ARB_PERF_EN adds the perf_grant_cnt and
// perf_coll_cnt counter outputs.
module sram_dp_arbiter
  import sram_arb_pkg::*;
#(
  parameter int         NREQ   = 4,
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter int         DATA_W = DATA_W_DEF,
  parameter logic [2:0] EMA    = EMA_DEF,
  parameter logic [1:0] EMAW   = EMAW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   sram_cen_a,
  output logic                   sram_cen_b,
  output logic                   sram_wen_a,
  output logic                   sram_wen_b,
  output logic [ADDR_W-1:0]      sram_a_a,
  output logic [ADDR_W-1:0]      sram_a_b,
  output logic [DATA_W-1:0]      sram_d_a,
  output logic [DATA_W-1:0]      sram_d_b,
  input  logic [DATA_W-1:0]      sram_q_a,
  input  logic [DATA_W-1:0]      sram_q_b,
  output logic                   sram_tena,
  output logic                   sram_tenb,
  output logic                   sram_ret1n,
  output logic                   sram_sea,
  output logic                   sram_seb,
  output logic                   sram_dftrambyp,
  output logic                   sram_colldisn,
  output logic [2:0]             sram_emaa,
  output logic [2:0]             sram_emab,
  output logic [1:0]             sram_emawa,
  output logic [1:0]             sram_emawb
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_grant_cnt,
  output logic [31:0]            perf_coll_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  // Test and DFT pins are tied to functional mode.
  assign sram_tena      = 1'b1;
  assign sram_tenb      = 1'b1;
  assign sram_ret1n     = 1'b1;
  assign sram_sea       = 1'b0;
  assign sram_seb       = 1'b0;
  assign sram_dftrambyp = 1'b0;
  assign sram_colldisn  = 1'b1;
  assign sram_emaa      = EMA;
  assign sram_emab      = EMA;
  assign sram_emawa     = EMAW;
  assign sram_emawb     = EMAW;

  tag_t tag1_a, tag2_a, tag1_b, tag2_b, hold_tag;
  logic [DATA_W-1:0] hold_data;

  logic [NREQ-1:0] eligible, mask_a, mask_b;
  logic [NREQ-1:0] grant_a, grant_b;
  logic [IDW-1:0]  id_a, id_b;
  logic            any_a, any_b, b_take, collision, hold_hazard;

  logic              we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] wdata_a, wdata_b;

  // Two reads in stage 1 on both ports means the B word will be held two
  // cycles from now; a read granted now would return into that held slot,
  // so reads sit out this one cycle while writes may still proceed.
  assign hold_hazard = tag1_a.valid & tag1_b.valid;
  assign eligible    = hold_hazard ? req_we : '1;
  assign mask_a      = eligible;
  assign mask_b      = eligible & ~grant_a;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .mask      (mask_a),
    .advance   (any_a),
    .grant     (grant_a),
    .grant_id  (id_a),
    .grant_any (any_a)
  );

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .mask      (mask_b),
    .advance   (b_take),
    .grant     (grant_b),
    .grant_id  (id_b),
    .grant_any (any_b)
  );

  // Steer the winning requester's command fields onto each port.
  always_comb begin
    we_a    = 1'b0;
    we_b    = 1'b0;
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (id_a == IDW'(i)) begin
        we_a    = req_we[i];
        addr_a  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_a = req_wdata[i*DATA_W +: DATA_W];
      end
      if (id_b == IDW'(i)) begin
        we_b    = req_we[i];
        addr_b  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_b = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Same address on both ports with any write is unsafe; B yields and retries.
  assign collision = any_a & any_b & (addr_a == addr_b) & (we_a | we_b);
  assign b_take    = any_b & ~collision;
  assign req_ready = grant_a | (b_take ? grant_b : '0);

  // Port A macro pins: load the accepted command, idle with CEN/WEN high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen_a <= 1'b1;
      sram_wen_a <= 1'b1;
      sram_a_a   <= '0;
      sram_d_a   <= '0;
    end else begin
      sram_cen_a <= ~any_a;
      sram_wen_a <= ~(any_a & we_a);
      if (any_a) begin
        sram_a_a <= addr_a;
        if (we_a) begin
          sram_d_a <= wdata_a;
        end
      end
    end
  end

  // Port B macro pins: same as A but only for a grant that survived collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_cen_b <= 1'b1;
      sram_wen_b <= 1'b1;
      sram_a_b   <= '0;
      sram_d_b   <= '0;
    end else begin
      sram_cen_b <= ~b_take;
      sram_wen_b <= ~(b_take & we_b);
      if (b_take) begin
        sram_a_b <= addr_b;
        if (we_b) begin
          sram_d_b <= wdata_b;
        end
      end
    end
  end

  // Read tag pipes: stage 1 rides with the macro access, stage 2 with its Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_a <= '0;
      tag2_a <= '0;
      tag1_b <= '0;
      tag2_b <= '0;
    end else begin
      tag1_a <= '{valid: any_a & ~we_a, id: ID_W'(id_a)};
      tag1_b <= '{valid: b_take & ~we_b, id: ID_W'(id_b)};
      tag2_a <= tag1_a;
      tag2_b <= tag1_b;
    end
  end

  // Park the B word for one cycle when both ports return together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_tag  <= '0;
      hold_data <= '0;
    end else begin
      hold_tag <= '{valid: tag2_a.valid & tag2_b.valid, id: tag2_b.id};
      if (tag2_a.valid && tag2_b.valid) begin
        hold_data <= sram_q_b;
      end
    end
  end

  // Response bus: flag every returning requester; A's word wins the data bus,
  // and the B requester's bit stays up through the cycle its held word shows.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_hit(tag2_a, i) || tag_hit(tag2_b, i) || tag_hit(hold_tag, i)) begin
        rsp_valid[i] = 1'b1;
      end
    end
    if (hold_tag.valid) begin
      rsp_rdata = hold_data;
    end else if (tag2_a.valid) begin
      rsp_rdata = sram_q_a;
    end else if (tag2_b.valid) begin
      rsp_rdata = sram_q_b;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  // Count accepted requests and B grants lost to address collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_coll_cnt  <= '0;
    end else begin
      perf_grant_cnt <= perf_grant_cnt + 32'(any_a) + 32'(b_take);
      perf_coll_cnt  <= perf_coll_cnt + 32'(collision);
    end
  end
`endif

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Directed bench for sram_dp_arbiter with a behavioural dual-port SRAM model
// hanging off the macro pins. Perf counter checks are compiled in when
// SRAM_ARB_PERF_EN is defined.
module tb_sram_dp_arbiter;
  import sram_arb_pkg::*;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   sram_cen_a, sram_cen_b, sram_wen_a, sram_wen_b;
  logic [ADDR_W-1:0]      sram_a_a, sram_a_b;
  logic [DATA_W-1:0]      sram_d_a, sram_d_b, sram_q_a, sram_q_b;
  logic                   sram_tena, sram_tenb, sram_ret1n, sram_sea, sram_seb;
  logic                   sram_dftrambyp, sram_colldisn;
  logic [2:0]             sram_emaa, sram_emab;
  logic [1:0]             sram_emawa, sram_emawb;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0]            perf_grant_cnt, perf_coll_cnt;
`endif

  logic [DATA_W-1:0] mem [256];
  int assert_cnt = 0;
  int fail_cnt   = 0;
  int grant_tally [NREQ];
  logic [NREQ-1:0] rr_exp [4];

  sram_dp_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cen_a(sram_cen_a), .sram_cen_b(sram_cen_b),
    .sram_wen_a(sram_wen_a), .sram_wen_b(sram_wen_b),
    .sram_a_a(sram_a_a), .sram_a_b(sram_a_b),
    .sram_d_a(sram_d_a), .sram_d_b(sram_d_b),
    .sram_q_a(sram_q_a), .sram_q_b(sram_q_b),
    .sram_tena(sram_tena), .sram_tenb(sram_tenb), .sram_ret1n(sram_ret1n),
    .sram_sea(sram_sea), .sram_seb(sram_seb), .sram_dftrambyp(sram_dftrambyp),
    .sram_colldisn(sram_colldisn), .sram_emaa(sram_emaa), .sram_emab(sram_emab),
    .sram_emawa(sram_emawa), .sram_emawb(sram_emawb)
`ifdef SRAM_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_coll_cnt(perf_coll_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural macro: active-low enables, Q updates only on a read access.
  always @(posedge clk) begin
    if (!sram_cen_a) begin
      if (!sram_wen_a) mem[sram_a_a] <= sram_d_a;
      else             sram_q_a <= mem[sram_a_a];
    end
    if (!sram_cen_b) begin
      if (!sram_wen_b) mem[sram_a_b] <= sram_d_b;
      else             sram_q_b <= mem[sram_a_b];
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of sequence, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic req_t wr(input logic [7:0] a, input logic [63:0] d);
    return '{we: 1'b1, addr: a, wdata: d};
  endfunction

  function automatic req_t rd(input logic [7:0] a);
    return '{we: 1'b0, addr: a, wdata: 64'h0};
  endfunction

  task automatic applyStimulus(input int idx, input logic valid, input req_t r);
    req_valid[idx]                    = valid;
    req_we[idx]                       = r.we;
    req_addr[idx*ADDR_W +: ADDR_W]    = r.addr;
    req_wdata[idx*DATA_W +: DATA_W]   = r.wdata;
  endtask

  task automatic clearAll();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // With everyone pending, A walks 0,1,2,3 and B takes the next one after A.
    rr_exp[0] = 4'b0011;
    rr_exp[1] = 4'b0110;
    rr_exp[2] = 4'b1100;
    rr_exp[3] = 4'b1001;
    foreach (grant_tally[i]) grant_tally[i] = 0;

    rst_n = 1'b0;
    clearAll();
    step();
    step();
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_ready", req_ready, 4'b0000);
    checkOutput("rst_rsp_valid", rsp_valid, 4'b0000);
    checkOutput("rst_cen_a", sram_cen_a, 1'b1);
    checkOutput("rst_cen_b", sram_cen_b, 1'b1);
    checkOutput("rst_wen_a", sram_wen_a, 1'b1);
    checkOutput("rst_wen_b", sram_wen_b, 1'b1);
    checkOutput("rst_addr_a", sram_a_a, 8'h00);
    checkOutput("rst_d_b", sram_d_b, 64'h0);
    checkOutput("tie_emaa", sram_emaa, 3'b011);
    checkOutput("tie_emawb", sram_emawb, 2'b01);
    checkOutput("tie_ret1n_colldisn", {sram_ret1n, sram_colldisn, sram_tena}, 3'b111);
    checkOutput("tie_se_byp", {sram_sea, sram_seb, sram_dftrambyp}, 3'b000);
    step();
    rst_n = 1'b1;

    $display("[TB] write then read back");
    applyStimulus(0, 1'b1, wr(8'h05, 64'hDEAD_BEEF));
    @(negedge clk);
    checkOutput("t1_wr_ready", req_ready, 4'b0001);
    step();
    applyStimulus(0, 1'b0, rd(8'h00));
    applyStimulus(1, 1'b1, rd(8'h05));
    @(negedge clk);
    checkOutput("t1_rd_ready", req_ready, 4'b0010);
    checkOutput("t1_wr_pins", {sram_cen_a, sram_wen_a, sram_cen_b, sram_a_a}, {3'b001, 8'h05});
    checkOutput("t1_wr_data", sram_d_a, 64'hDEAD_BEEF);
    step();
    applyStimulus(1, 1'b0, rd(8'h00));
    @(negedge clk);
    checkOutput("t1_rd_pins", {sram_cen_a, sram_wen_a, sram_a_a}, {2'b01, 8'h05});
    checkOutput("t1_rsp_early", rsp_valid, 4'b0000);
    step();
    @(negedge clk);
    checkOutput("t1_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("t1_rsp_data", rsp_rdata, 64'hDEAD_BEEF);
    step();
    @(negedge clk);
    checkOutput("t1_rsp_pulse_end", rsp_valid, 4'b0000);
    step();

    $display("[TB] all requesters pending");
    doReset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        applyStimulus(i, 1'b1, wr(8'(8'h40 + i), 64'(64'h100 + c)));
      end
      @(negedge clk);
      checkOutput($sformatf("t2_ready_c%0d", c), req_ready, rr_exp[c % 4]);
      for (int i = 0; i < NREQ; i++) grant_tally[i] += int'(req_ready[i]);
      if (c > 0) begin
        checkOutput($sformatf("t2_addr_a_c%0d", c), sram_a_a, 8'(8'h40 + ((c - 1) % 4)));
        checkOutput($sformatf("t2_addr_b_c%0d", c), sram_a_b, 8'(8'h40 + (c % 4)));
      end
      step();
    end
    clearAll();
    for (int i = 0; i < NREQ; i++) begin
      checkOutput($sformatf("t2_tally_%0d", i), grant_tally[i], 4);
    end

    $display("[TB] write/read collision");
    doReset();
    applyStimulus(0, 1'b1, wr(8'h10, 64'h1111_2222_3333_4444));
    applyStimulus(1, 1'b1, rd(8'h10));
    @(negedge clk);
    checkOutput("t3_ready_c0", req_ready, 4'b0001);
    step();
    applyStimulus(0, 1'b0, rd(8'h00));
    @(negedge clk);
    checkOutput("t3_ready_c1", req_ready, 4'b0010);
    checkOutput("t3_pins_c1", {sram_cen_a, sram_wen_a, sram_cen_b}, 3'b001);
    step();
    applyStimulus(1, 1'b0, rd(8'h00));
    @(negedge clk);
    checkOutput("t3_pins_c2", {sram_cen_a, sram_wen_a, sram_a_a}, {2'b01, 8'h10});
    step();
    @(negedge clk);
    checkOutput("t3_rsp_valid", rsp_valid, 4'b0010);
    checkOutput("t3_rsp_data", rsp_rdata, 64'h1111_2222_3333_4444);
`ifdef SRAM_ARB_PERF_EN
    checkOutput("t3_perf_grant", perf_grant_cnt, 32'd2);
    checkOutput("t3_perf_coll", perf_coll_cnt, 32'd1);
`endif
    step();

    $display("[TB] read/read same address and held B word");
    applyStimulus(2, 1'b1, wr(8'h20, 64'hA5A5_0000_5A5A_FFFF));
    @(negedge clk);
    checkOutput("t4_wr_ready", req_ready, 4'b0100);
    step();
    applyStimulus(2, 1'b0, rd(8'h00));
    applyStimulus(0, 1'b1, rd(8'h20));
    applyStimulus(1, 1'b1, rd(8'h20));
    @(negedge clk);
    checkOutput("t4_rr_ready", req_ready, 4'b0011);
    step();
    applyStimulus(0, 1'b0, rd(8'h00));
    applyStimulus(1, 1'b0, rd(8'h00));
    applyStimulus(2, 1'b1, rd(8'h05));
    @(negedge clk);
    checkOutput("t4_stall_ready", req_ready, 4'b0000);
    step();
    @(negedge clk);
    checkOutput("t4_retry_ready", req_ready, 4'b0100);
    checkOutput("t4_rsp_both", rsp_valid, 4'b0011);
    checkOutput("t4_rsp_data_a", rsp_rdata, 64'hA5A5_0000_5A5A_FFFF);
    step();
    applyStimulus(2, 1'b0, rd(8'h00));
    @(negedge clk);
    checkOutput("t4_rsp_held", rsp_valid, 4'b0010);
    checkOutput("t4_rsp_data_b", rsp_rdata, 64'hA5A5_0000_5A5A_FFFF);
    step();
    @(negedge clk);
    checkOutput("t4_rsp_retry", rsp_valid, 4'b0100);
    checkOutput("t4_rsp_retry_data", rsp_rdata, 64'hDEAD_BEEF);
`ifdef SRAM_ARB_PERF_EN
    checkOutput("t4_perf_grant", perf_grant_cnt, 32'd6);
    checkOutput("t4_perf_coll", perf_coll_cnt, 32'd1);
`endif
    step();

    $display("[TB] reset during a read");
    applyStimulus(1, 1'b1, rd(8'h05));
    @(negedge clk);
    checkOutput("t5_rd_ready", req_ready, 4'b0010);
    step();
    applyStimulus(1, 1'b0, rd(8'h00));
    @(negedge clk);
    checkOutput("t5_cen_before", sram_cen_a, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_cen_async", sram_cen_a, 1'b1);
    step();
    @(negedge clk);
    checkOutput("t5_rsp_flush_c2", rsp_valid, 4'b0000);
    step();
    @(negedge clk);
    checkOutput("t5_rsp_flush_c3", rsp_valid, 4'b0000);
    step();
    rst_n = 1'b1;
    applyStimulus(1, 1'b1, wr(8'h31, 64'h31));
    applyStimulus(2, 1'b1, wr(8'h32, 64'h32));
    @(negedge clk);
    checkOutput("t5_ready_after", req_ready, 4'b0110);
    step();
    clearAll();
    @(negedge clk);
    checkOutput("t5_ptr_a_reset", sram_a_a, 8'h31);
    checkOutput("t5_ptr_b_reset", sram_a_b, 8'h32);
    checkOutput("t5_rsp_after", rsp_valid, 4'b0000);
    step();

    $display("[TB] address boundaries through both ports");
    applyStimulus(0, 1'b1, wr(8'hFF, 64'h0123_4567_89AB_CDEF));
    applyStimulus(1, 1'b1, wr(8'h00, 64'hFEDC_BA98_7654_3210));
    @(negedge clk);
    checkOutput("t6_wr_ready", req_ready, 4'b0011);
    step();
    applyStimulus(0, 1'b1, rd(8'h00));
    applyStimulus(1, 1'b1, rd(8'hFF));
    @(negedge clk);
    checkOutput("t6_rd_ready", req_ready, 4'b0011);
    checkOutput("t6_wr_pins", {sram_wen_a, sram_a_a, sram_wen_b, sram_a_b}, {1'b0, 8'hFF, 1'b0, 8'h00});
    checkOutput("t6_wr_d_a", sram_d_a, 64'h0123_4567_89AB_CDEF);
    checkOutput("t6_wr_d_b", sram_d_b, 64'hFEDC_BA98_7654_3210);
    step();
    clearAll();
    @(negedge clk);
    checkOutput("t6_rd_pins", {sram_wen_a, sram_a_a, sram_wen_b, sram_a_b}, {1'b1, 8'hFF, 1'b1, 8'h00});
    step();
    @(negedge clk);
    checkOutput("t6_rsp_both", rsp_valid, 4'b0011);
    checkOutput("t6_rsp_data_a", rsp_rdata, 64'h0123_4567_89AB_CDEF);
    step();
    @(negedge clk);
    checkOutput("t6_rsp_held", rsp_valid, 4'b0001);
    checkOutput("t6_rsp_data_b", rsp_rdata, 64'hFEDC_BA98_7654_3210);
    step();
    @(negedge clk);
    checkOutput("t6_rsp_idle", rsp_valid, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
